// File: rtl/heartbeat_conditioner.sv
// Heartbeat front-end: synchronizer, debouncer, beat acceptance FSM with refractory blanking, loss-of-beat timeout.
// Define HEARTBEAT_REJECT_CNT_EN to build the saturating rejected-beat counter; otherwise reject_cnt reads 0.
//
// state    | meaning
// ARMED    | waiting for a debounced rising edge
// PULSE    | beat accepted, beat_out held high for PULSE_LEN cycles
// BLANK    | refractory window, candidates rejected
// WAIT_LOW | refractory over, waiting for debounced level to return low
module heartbeat_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int PULSE_LEN    = 16,
  parameter int REFRACT_CYC  = 12500000,
  parameter int TIMEOUT_CYC  = 150000000,
  parameter int CNT_W        = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_in,
  output logic       beat_out,
  output logic       beat_pulse,
  output logic       no_beat,
  output logic [7:0] reject_cnt
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PLS_W = $clog2(PULSE_LEN + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRACT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYC);
  localparam bit SKIP_BLANK = (PULSE_LEN >= REFRACT_CYC);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    PULSE    = 2'd1,
    BLANK    = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   deb_q;
  logic                   deb_prev_q;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   cand;

  state_t           state_q, state_d;
  logic [PLS_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] tcnt_q;
  logic             beat_out_d;
  logic             beat_pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in};
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Any return to agreement restarts the stability count, so short glitches never toggle deb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (s_sync == deb_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_q   <= ~deb_q;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign cand = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARMED;
      pcnt_q     <= '0;
      rcnt_q     <= '0;
      beat_out   <= 1'b0;
      beat_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      rcnt_q     <= rcnt_d;
      beat_out   <= beat_out_d;
      beat_pulse <= beat_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    rcnt_d       = rcnt_q;
    beat_out_d   = beat_out;
    beat_pulse_d = 1'b0;
    case (state_q)
      ARMED: begin
        if (cand) begin
          state_d      = PULSE;
          beat_out_d   = 1'b1;
          beat_pulse_d = 1'b1;
          pcnt_d       = PLS_LAST;
          rcnt_d       = '0;
        end
      end
      PULSE: begin
        rcnt_d = rcnt_q + CNT_W'(1);
        if (pcnt_q == '0) begin
          beat_out_d = 1'b0;
          state_d    = SKIP_BLANK ? WAIT_LOW : BLANK;
        end else begin
          pcnt_d = pcnt_q - PLS_W'(1);
        end
      end
      BLANK: begin
        rcnt_d = rcnt_q + CNT_W'(1);
        if (rcnt_q >= REF_LAST) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!deb_q) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  // Cleared from the registered strobe so no_beat falls one cycle after beat_pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tcnt_q <= '0;
    else if (beat_pulse)      tcnt_q <= '0;
    else if (tcnt_q != TO_MAX) tcnt_q <= tcnt_q + CNT_W'(1);
  end

  assign no_beat = (tcnt_q == TO_MAX);

`ifdef HEARTBEAT_REJECT_CNT_EN
  logic reject;
  assign reject = cand && ((state_q == PULSE) || (state_q == BLANK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              reject_cnt <= 8'd0;
    else if (reject && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
  end
`else
  assign reject_cnt = 8'd0;
`endif

endmodule
